// File: rtl/ifetch_stage.sv
// Instruction fetch stage: request/response handshake with instruction memory,
// instruction register with flush/drain handling and control-flow immediate decode.
module ifetch_stage #(
  parameter logic [31:0] NOP_INST = 32'h00000013,
  parameter int          MAX_WAIT = 15
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IP,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [6:0]  OP,
  output logic [31:0] up_amt,
  output logic        fetch_busy,
  output logic        fetch_err
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     inst_q, inst_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            timeout;

  assign timeout = (cnt_q == CW'(MAX_WAIT));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    inst_d  = inst_q;
    valid_d = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        addr_d  = IP & 32'hFFFF_FFFC;
        cnt_d   = '0;
        state_d = flush ? IDLE : REQ;
      end
      REQ: begin
        cnt_d = '0;
        // A grant coinciding with flush still owes us a response, so drain it.
        if (flush)         state_d = imem_gnt ? DRAIN : IDLE;
        else if (imem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (flush) begin
          state_d = IDLE;
        end else if (imem_rvalid) begin
          inst_d  = imem_rdata;
          valid_d = 1'b1;
          state_d = IDLE;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (imem_rvalid) begin
          state_d = IDLE;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      inst_d  = NOP_INST;
      valid_d = 1'b0;
      if (state_q != DRAIN) cnt_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      addr_q  <= '0;
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Immediate decode feeds the PC stage's offset input for JAL/branch/JALR.
  always_comb begin
    case (inst_q[6:0])
      7'b1101111: up_amt = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20],
                            inst_q[30:21], 1'b0};
      7'b1100011: up_amt = {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25],
                            inst_q[11:8], 1'b0};
      7'b1100111: up_amt = {{20{inst_q[31]}}, inst_q[31:20]};
      default:    up_amt = 32'd0;
    endcase
  end

  assign imem_req   = (state_q == REQ);
  assign imem_addr  = addr_q;
  assign inst       = inst_q;
  assign inst_valid = valid_q;
  assign OP         = inst_q[6:0];
  assign fetch_busy = (state_q != IDLE);
  assign fetch_err  = err_q;

endmodule

// File: tb/tb_ifetch_stage.sv
// Scoreboard bench for ifetch_stage: directed handshake/flush/timeout cases
// followed by randomized traffic against a transaction-level memory model.
module tb_ifetch_stage;

  localparam logic [31:0] NOP  = 32'h00000013;
  localparam int          MAXW = 15;

  logic        CLK, RESET, flush, imem_gnt, imem_rvalid;
  logic [31:0] IP, imem_rdata;
  logic        imem_req, inst_valid, fetch_busy, fetch_err;
  logic [31:0] imem_addr, inst, up_amt;
  logic [6:0]  OP;

  int          testsRun = 0;
  int          testsFailed = 0;
  int          cycleCnt = 0;
  int          lastReqCycle = 0;
  logic [31:0] expQ[$];

  ifetch_stage #(.NOP_INST(NOP), .MAX_WAIT(MAXW)) dut (
    .CLK(CLK), .RESET(RESET), .IP(IP), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst(inst), .inst_valid(inst_valid), .OP(OP), .up_amt(up_amt),
    .fetch_busy(fetch_busy), .fetch_err(fetch_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cycleCnt <= cycleCnt + 1;

  // Immediates rebuilt as weighted sums of instruction fields, MSB weight negative.
  function automatic logic [31:0] refUpAmt(input logic [31:0] w);
    longint v;
    v = 0;
    case (w[6:0])
      7'b1101111: v = longint'(w[30:21]) * 2 + longint'(w[20]) * 2048
                      + longint'(w[19:12]) * 4096 - (w[31] ? 64'sd1048576 : 64'sd0);
      7'b1100011: v = longint'(w[11:8]) * 2 + longint'(w[30:25]) * 32
                      + longint'(w[7]) * 2048 - (w[31] ? 64'sd4096 : 64'sd0);
      7'b1100111: v = longint'(w[30:20]) - (w[31] ? 64'sd2048 : 64'sd0);
      default:    v = 0;
    endcase
    return v[31:0];
  endfunction

  function automatic logic [31:0] randInst();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 4))
      0: w[6:0] = 7'b1101111;
      1: w[6:0] = 7'b1100011;
      2: w[6:0] = 7'b1100111;
      3: w[6:0] = 7'b0010011;
      default: w[6:0] = 7'b0110011;
    endcase
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: pops the scoreboard on every inst_valid and polices addr/flush rules.
  logic        prevReq = 1'b0, prevFlush = 1'b0, prevReset = 1'b0, prevValid = 1'b0;
  logic [31:0] prevIP = '0, prevAddr = '0;
  always @(negedge CLK) begin
    logic [31:0] w;
    if (inst_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected_valid: got inst %h with no fetch expected", inst);
      end else begin
        w = expQ.pop_front();
        checkOutput("sb_inst", inst, w);
        checkOutput("sb_op", 32'(OP), 32'(w[6:0]));
        checkOutput("sb_up_amt", up_amt, refUpAmt(w));
      end
      checkOutput("valid_single_cycle", 32'(prevValid), 32'd0);
    end
    if (prevFlush || prevReset) begin
      checkOutput("inst_after_flush", inst, NOP);
      checkOutput("valid_after_flush", 32'(inst_valid), 32'd0);
    end
    if (imem_req === 1'b1 && !prevReq)     checkOutput("req_addr", imem_addr, prevIP & 32'hFFFF_FFFC);
    else if (imem_req === 1'b1 && prevReq) checkOutput("addr_stable", imem_addr, prevAddr);
    prevReq   = (imem_req === 1'b1);
    prevIP    = IP;
    prevAddr  = imem_addr;
    prevFlush = flush;
    prevReset = RESET;
    prevValid = (inst_valid === 1'b1);
  end

  // One complete fetch starting from an IDLE cycle, ending in the IDLE cycle with inst_valid.
  task automatic doFetch(input logic [31:0] ipVal, input int gntWait, input int rvWait,
                         input logic [31:0] data);
    checkOutput("idle_not_busy", 32'(fetch_busy), 32'd0);
    IP = ipVal;
    tick();
    lastReqCycle = cycleCnt;
    for (int i = 0; i < gntWait; i++) begin
      checkOutput("bp_req", 32'(imem_req), 32'd1);
      checkOutput("bp_addr", imem_addr, ipVal & 32'hFFFF_FFFC);
      IP = $urandom;
      tick();
    end
    checkOutput("req_high", 32'(imem_req), 32'd1);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    checkOutput("wait_req_low", 32'(imem_req), 32'd0);
    checkOutput("wait_busy", 32'(fetch_busy), 32'd1);
    repeat (rvWait) tick();
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    expQ.push_back(data);
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    checkOutput("fetch_valid", 32'(inst_valid), 32'd1);
    checkOutput("fetch_inst", inst, data);
  endtask

  task automatic applyStimulus(input int cycles);
    logic        pending = 1'b0, drain = 1'b0, active;
    int          delay = 0;
    logic [31:0] pdata = '0;
    int          extra = 0;
    for (int c = 0; c < cycles + 40; c++) begin
      active = (c < cycles);
      if (!active && !pending) break;
      flush       = active && ($urandom_range(0, 9) == 0);
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      IP          = $urandom;
      if (pending) begin
        if (delay == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = pdata;
        end else begin
          delay--;
        end
      end else begin
        if (imem_req && active) imem_gnt = ($urandom_range(0, 1) == 1);
        if (!imem_req && $urandom_range(0, 7) == 0) imem_rvalid = 1'b1;
      end
      @(negedge CLK);
      if (imem_rvalid && pending) begin
        if (!drain && !flush) expQ.push_back(pdata);
        pending = 1'b0;
      end else if (imem_req && imem_gnt) begin
        pending = 1'b1;
        drain   = flush;
        delay   = $urandom_range(0, 4);
        pdata   = randInst();
      end else if (pending && flush && !drain) begin
        pending = 1'b0;
      end
      tick();
      extra = c;
    end
    flush = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    checkOutput("random_drained", 32'(pending), 32'd0);
    tick();
    tick();
    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
    checkOutput("random_no_err", 32'(fetch_err), 32'd0);
    if (extra < 0) $display("[TB] unreachable");
  endtask

  initial begin
    int n;
    RESET = 1'b1; flush = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = '0; IP = '0;
    tick();
    tick();
    RESET = 1'b0;
    checkOutput("rst_inst", inst, NOP);
    checkOutput("rst_op", 32'(OP), 32'h13);
    checkOutput("rst_up_amt", up_amt, 32'd0);
    checkOutput("rst_req", 32'(imem_req), 32'd0);
    checkOutput("rst_addr", imem_addr, 32'd0);
    checkOutput("rst_valid", 32'(inst_valid), 32'd0);
    checkOutput("rst_err", 32'(fetch_err), 32'd0);

    doFetch(32'h40, 0, 0, 32'h008000EF);
    checkOutput("jal_op", 32'(OP), 32'h6F);
    checkOutput("jal_up_amt", up_amt, 32'd8);
    n = lastReqCycle;
    doFetch(32'h44, 0, 0, 32'hFE000EE3);
    checkOutput("throughput", 32'(lastReqCycle - n), 32'd3);
    checkOutput("br_op", 32'(OP), 32'h63);
    checkOutput("br_up_amt", up_amt, 32'hFFFFFFFC);
    doFetch(32'h48, 0, 1, 32'hFFC08067);
    checkOutput("jalr_up_amt", up_amt, 32'hFFFFFFFC);
    doFetch(32'h107, 4, 2, 32'h00A00093);
    checkOutput("addi_up_amt", up_amt, 32'd0);

    // Flush together with grant: response must be drained and dropped.
    IP = 32'h200;
    tick();
    imem_gnt = 1'b1; flush = 1'b1;
    tick();
    imem_gnt = 1'b0; flush = 1'b0;
    checkOutput("drain_busy", 32'(fetch_busy), 32'd1);
    checkOutput("drain_req", 32'(imem_req), 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("drain_hold_on_flush", 32'(fetch_busy), 32'd1);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h008000EF;
    tick();
    imem_rvalid = 1'b0;
    checkOutput("drain_no_valid", 32'(inst_valid), 32'd0);
    checkOutput("drain_inst_nop", inst, NOP);
    checkOutput("drain_done", 32'(fetch_busy), 32'd0);

    // Flush together with response in WAIT.
    doFetch(32'h300, 0, 0, 32'h008000EF);
    IP = 32'h304;
    tick();
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; flush = 1'b1; imem_rdata = 32'hFE000EE3;
    tick();
    imem_rvalid = 1'b0; flush = 1'b0;
    checkOutput("wflush_no_valid", 32'(inst_valid), 32'd0);
    checkOutput("wflush_inst_nop", inst, NOP);
    checkOutput("wflush_idle", 32'(fetch_busy), 32'd0);

    // Timeout: memory never answers.
    doFetch(32'h400, 0, 0, 32'h008000EF);
    IP = 32'h404;
    tick();
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    n = 0;
    while (fetch_err !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checkOutput("timeout_err", 32'(fetch_err), 32'd1);
    checkOutput("timeout_latency_ok", 32'(n == MAXW || n == MAXW + 1), 32'd1);
    checkOutput("timeout_idle", 32'(fetch_busy), 32'd0);
    checkOutput("timeout_inst_kept", inst, 32'h008000EF);
    doFetch(32'h500, 1, 0, 32'hFFC08067);
    checkOutput("err_sticky", 32'(fetch_err), 32'd1);

    // Reset in the middle of WAIT.
    IP = 32'h600;
    tick();
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; RESET = 1'b1;
    tick();
    RESET = 1'b0;
    checkOutput("mid_rst_err", 32'(fetch_err), 32'd0);
    checkOutput("mid_rst_inst", inst, NOP);
    checkOutput("mid_rst_idle", 32'(fetch_busy), 32'd0);

    applyStimulus(3000);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/ifetch_stage.md
Name: ifetch_stage

Overview:
- Instruction fetch stage directly downstream of the program counter.
- Takes the current instruction pointer, runs a request/response handshake with instruction memory, and holds the returned word in an instruction register.
- Decodes opcode and control-flow immediate (JAL/JALR/branch) from the held word; these become the opcode and branch-offset inputs of the PC stage.
- Supports flush of an in-flight fetch when a control-flow redirect occurs.

Parameters:
- NOP_INST, 32'h00000013, instruction presented after reset and after flush (addi x0,x0,0).
- MAX_WAIT, 15, response-wait cycles before the timeout error fires; also the wait-counter limit.

Ports:
- CLK  input  1  clock, all state on rising edge.
- RESET  input  1  synchronous active-high reset.
- IP  input  32  current instruction pointer from PC stage.
- flush  input  1  discard in-flight/held fetch (redirect taken).
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch address, word aligned (IP with bits [1:0] forced 0).
- imem_gnt  input  1  memory accepted request this cycle.
- imem_rvalid  input  1  response data valid this cycle.
- imem_rdata  input  32  response instruction word.
- inst  output  32  instruction register.
- inst_valid  output  1  one-cycle pulse: new instruction in inst.
- OP  output  7  inst[6:0].
- up_amt  output  32  sign-extended control-flow offset of inst.
- fetch_busy  output  1  high in REQ or WAIT.
- fetch_err  output  1  sticky timeout flag.

Behaviour:
- Reset (RESET high at edge, any state):
  - state=IDLE, inst=NOP_INST, inst_valid=0, imem_req=0, imem_addr=0, fetch_err=0, wait counter=0.
  - RESET overrides flush and all handshake inputs.
- States:
  - IDLE: latch imem_addr from IP; go to REQ next cycle.
  - REQ: imem_req=1, imem_addr held stable. If imem_gnt, go to WAIT; else stay.
  - WAIT: imem_req=0, counter increments each cycle. If imem_rvalid, load inst=imem_rdata, pulse inst_valid next cycle, go to IDLE.
- Throughput: best case IDLE->REQ->WAIT->IDLE. With gnt in the REQ cycle and rvalid in the first WAIT cycle, there is one instruction every 3 cycles; inst_valid rises on the edge that leaves WAIT.
- imem_rvalid outside WAIT: ignored.
- flush:
  - Any state: next state=IDLE, inst=NOP_INST, inst_valid=0, counter=0.
  - Flush in WAIT with simultaneous rvalid: data dropped, NOP_INST loaded, no inst_valid.
  - Flush in REQ with simultaneous gnt: request considered accepted. The block enters DRAIN (a fourth state), waits for rvalid and discards it, then goes to IDLE. flush during DRAIN: stay in DRAIN.
  - fetch_busy is high in DRAIN.
- Timeout:
  - In WAIT or DRAIN, counter==MAX_WAIT without rvalid sets fetch_err=1 (sticky until RESET) and forces IDLE, inst unchanged.
- Decode (combinational from inst):
  - OP = inst[6:0].
  - 1101111 (JAL): up_amt = sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - 1100011 (branch): up_amt = sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - 1100111 (JALR): up_amt = sext(inst[31:20]).
  - Other opcodes: up_amt = 0.
  - Sign extension is from the immediate MSB to 32 bits; no wraparound handling is needed beyond 32-bit two's complement.
- inst holds its value between fetches; inst_valid is never high two consecutive cycles.

Test Plan:
- Reset then idle memory: RESET 2 cycles, release -> inst=32'h00000013, OP=7'b0010011, up_amt=0, imem_req=1 one cycle after leaving IDLE with imem_addr=IP.
- Zero-wait fetch: IP=32'h40, gnt in REQ cycle, rvalid+rdata=32'h008000EF (jal x1,8) in first WAIT cycle -> inst_valid pulse once, OP=7'b1101111, up_amt=32'd8.
- Negative branch: rdata=32'hFE000EE3 (beq x0,x0,-4) -> OP=7'b1100011, up_amt=32'hFFFFFFFC; JALR rdata=32'hFFC08067 -> up_amt=32'hFFFFFFFC.
- Backpressure: gnt held low 4 cycles -> imem_req high and imem_addr stable all 4 cycles. IP changing mid-REQ does not alter imem_addr.
- Flush races: flush with gnt in REQ -> DRAIN, later rvalid discarded, no inst_valid, inst=NOP_INST. flush with rvalid in WAIT -> no inst_valid, inst=NOP_INST.
- Timeout and reset mid-operation: no rvalid for MAX_WAIT cycles -> fetch_err=1, state IDLE, fetch_err stays 1 through later fetches. RESET asserted in WAIT -> fetch_err=0, inst=NOP_INST next cycle.
